inst_fetch_responder: RTL
=========================

# inst_fetch_responder

Instruction-memory responder on the far end of the fetch interface. It accepts a word-aligned PC request from the IF stage and returns the instruction after a fixed multi-cycle latency. While the access is pending it drives the `freeze` stall back into the pipeline. A branch-driven `cancel` aborts in-flight accesses, and a load port preloads program words before or during a run.

## Interface
Parameters:
- `ADDR_W`, default `` `ADDRESS_LEN `` (32): request address width.
- `DATA_W`, default `` `INSTRUCTION_LEN `` (32): instruction width.
- `DEPTH`, default 1024: number of instruction words; power of two.
- `LATENCY`, default 2: cycles from acceptance to response; legal range 1–15.

Ports:
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  fetch request present; must be held stable with `req_addr` while `freeze` = 1.
- `req_addr`  in  ADDR_W  byte address (PC).
- `cancel`  in  1  branch taken / flush; kills any pending or same-cycle access.
- `freeze`  out  1  stall request to the IF stage and IF stage register.
- `rsp_valid`  out  1  one-cycle strobe; the response is valid this cycle.
- `rsp_instr`  out  DATA_W  fetched instruction.
- `rsp_addr`  out  ADDR_W  address the response belongs to.
- `rsp_err`  out  1  misaligned or out-of-range access.
- `ld_en`  in  1  preload write enable.
- `ld_addr`  in  ADDR_W  byte address of the preload word.
- `ld_data`  in  DATA_W  preload word.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on `req_valid & ~cancel`, accept the request. Latch `req_addr` into `rsp_addr` and read the array into `rsp_instr`. Load the counter with LATENCY-1. Go to RESP if LATENCY = 1, else to WAIT.
  - WAIT: decrement the counter each cycle. Go to RESP when the counter reaches 1.
  - RESP: `rsp_valid` = 1. Return to IDLE next cycle unconditionally.
- `freeze` = `(IDLE & req_valid & ~cancel) | WAIT`. It is 0 in RESP, so the requester advances its PC on the RESP edge.
- `cancel` in any state: next state is IDLE. `rsp_valid` is forced to 0 in that cycle, and `freeze` is forced to 0. The cancelled access never produces a response.
- Error condition: `req_addr[1:0] != 0` or word index ≥ DEPTH.
  - The request is still accepted with the same latency.
  - The response carries `rsp_instr` = 0 (the NOP/bubble value) and `rsp_err` = 1.
- Load port:
  - `ld_en` writes word `ld_addr[log2(DEPTH)+1:2]`; the low two bits are ignored.
  - A load with an out-of-range address is dropped.
  - Loads are legal in any state.
- Read data is captured at acceptance, so later loads never alter an in-flight response. A same-cycle load to the word being accepted returns the old data (read-before-write).
- Array contents are not reset.

## Timing
- Reset values: state IDLE, counter 0, `rsp_valid` 0, `rsp_instr` 0, `rsp_addr` 0, `rsp_err` 0. `freeze` is 0 while `rst` = 1.
- Reset mid-access aborts it; no response follows.
- Accept at cycle t gives `rsp_valid` at t+LATENCY. `freeze` is high for cycles t through t+LATENCY-1.
- Throughput: one fetch per LATENCY+1 cycles. The cycle after RESP is always IDLE.
- `rsp_instr`, `rsp_addr` and `rsp_err` are registers. They hold their values after RESP until the next acceptance.
- `rsp_valid` and `freeze` are decoded from state and gated combinationally by `cancel` and `rst`.

## Structure
- Shared defines header (`Defines.v`) carries:
  - `ADDRESS_LEN` and `INSTRUCTION_LEN`;
  - the FSM state encodings (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - the NOP value 32'h0000_0000.
- Sub-module `inst_mem_array`: DEPTH×DATA_W, one synchronous write port, and one synchronous read port with a read enable. The read output is held when the read enable is low.
- FSM, counter, error decode and response registers live in `inst_fetch_responder`.

## Test plan
- Preload word 4 (`ld_addr` 0x10) = 0xE3A01005. With LATENCY = 2, request 0x10 at cycle 0. Expect `freeze` = 1 at cycles 0–1, and `rsp_valid` = 1 at cycle 2 with `rsp_instr` 0xE3A01005 and `rsp_addr` 0x10.
- Back-to-back PCs 0x0, 0x4, 0x8 with requester advancing on `freeze` = 0. Expect responses at cycles 2, 5, 8 in address order, with no duplicates.
- Assert `cancel` in the WAIT cycle of a fetch to 0x20. Expect no `rsp_valid` and IDLE next cycle. A new request to 0x40 then responds after LATENCY cycles.
- Request 0x6 (misaligned) and 0x1000 (≥ DEPTH×4). Each responds on schedule with `rsp_instr` 0 and `rsp_err` 1.
- Accept 0x10 while `ld_en` writes 0x10 = 0xDEADBEEF in the same cycle. Expect the old value returned; the next fetch of 0x10 returns 0xDEADBEEF.
- Assert `rst` during WAIT. Expect all outputs at reset values the next cycle, no response, and `freeze` = 0.

Source files
------------

// File: rtl/inst_fetch_responder_pkg.sv
// Shared widths, FSM state encodings and the bubble instruction for the
// instruction-fetch responder.
package inst_fetch_responder_pkg;

    localparam int ADDRESS_LEN     = 32;
    localparam int INSTRUCTION_LEN = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_responder_mem_array.sv
// Instruction storage: one synchronous write port and one synchronous read
// port whose output register holds its value while the read enable is low.
module inst_mem_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_fetch_responder.sv
// Fixed-latency instruction-memory responder: accepts a PC, stalls the fetch
// stage while the access is pending and returns the word, with cancel support.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int ADDR_W  = ADDRESS_LEN,
    parameter int DATA_W  = INSTRUCTION_LEN,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              cancel,
    output logic              freeze,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [DATA_W-1:0] mem_data;
    logic              accept;
    logic              req_err;
    logic              ld_ok;
    logic              unused_ld_low;

    assign accept  = (state_q == ST_IDLE) & req_valid & ~cancel & ~rst;
    assign req_err = (req_addr[1:0] != 2'b00) | ((req_addr >> (IDX_W + 2)) != '0);
    assign ld_ok   = ld_en & ((ld_addr >> (IDX_W + 2)) == '0);
    assign unused_ld_low = ^ld_addr[1:0];

    // Reading at acceptance (read-before-write) freezes the returned data.
    inst_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ld_ok),
        .wr_idx  (ld_addr[IDX_W+1:2]),
        .wr_data (ld_data),
        .rd_en   (accept),
        .rd_idx  (req_addr[IDX_W+1:2]),
        .rd_data (mem_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cancel) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        cnt_d   = CNT_INIT;
                        state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RESP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= req_addr;
                err_q  <= req_err;
            end
        end
    end

    assign freeze    = ~rst & ~cancel &
                       (((state_q == ST_IDLE) & req_valid) | (state_q == ST_WAIT));
    assign rsp_valid = ~rst & ~cancel & (state_q == ST_RESP);
    assign rsp_instr = err_q ? DATA_W'(NOP_INSTR) : mem_data;
    assign rsp_addr  = addr_q;
    assign rsp_err   = err_q;

endmodule
